div_sequencer: RTL and testbench
================================

DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 Parameter: args_width, default 32, operand/result width; SHALL be 8..128.
REQ-002 Clock and reset SHALL be one clock and an asynchronous, active-low reset, as follows:
  clk  in  1  sole clock, rising edge.
  rst_n  in  1  asynchronous, active-low reset.
REQ-003 Ports (name  direction  width  meaning) SHALL be:
  req_valid  in  1  request present.
  req_ready  out  1  sequencer accepts a request this cycle.
  req_sgn  in  1  1 = signed, 0 = unsigned.
  req_num, req_denom  in  args_width  numerator and denominator.
  req_tag  in  4  opaque tag, returned with the result.
  res_valid  out  1  result present.
  res_ready  in  1  consumer takes the result.
  res_quot, res_rem  out  args_width  quotient and remainder.
  res_tag  out  4  tag of the result.
  res_div_by_zero  out  1  result came from the zero-denominator bypass.
  div_enable  out  1  command strobe to the divider.
  div_unsgn_or_sgn  out  1  signedness to the divider.
  div_num, div_denom  out  args_width  operands to the divider.
  div_quot, div_rem  in  args_width  divider results.
  div_can_accept_cmd, div_data_ready  in  1  divider status; the divider has no reset.

Function
REQ-004 States SHALL be IDLE, ISSUE, WAIT_BUSY, WAIT_DONE and HOLD.
REQ-005 req_ready SHALL be 1 exactly when the state is IDLE; a request is accepted on a rising edge with req_valid && req_ready.
REQ-006 On accept, req_sgn/num/denom/tag SHALL be latched, and latched values SHALL drive div_unsgn_or_sgn, div_num and div_denom until the next accept.
REQ-007 Zero-denominator bypass: if req_denom == 0 on accept, then:
  res_quot = all ones and res_rem = req_num;
  res_div_by_zero = 1;
  next state is HOLD, so res_valid is high in the cycle after the accept edge;
  the divider SHALL NOT be enabled.
REQ-008 Signed-overflow bypass: if req_sgn && req_num == 2^(args_width-1) && req_denom == all ones, then:
  res_quot = req_num, res_rem = 0, res_div_by_zero = 0;
  next state is HOLD;
  the divider SHALL NOT be enabled.
REQ-009 Any other accept SHALL go to ISSUE.
REQ-010 In ISSUE, div_enable SHALL be 1 combinationally only while div_can_accept_cmd == 1, and the state SHALL then go to WAIT_BUSY on that edge. While the divider is still busy, the state SHALL stay in ISSUE with div_enable 0.
REQ-011 div_enable SHALL be 1 for exactly one cycle per divider-bound request and 0 in every other state.
REQ-012 WAIT_BUSY SHALL go to WAIT_DONE on the first cycle with div_can_accept_cmd == 0. This ignores the stale div_data_ready left over from the previous command.
REQ-013 WAIT_DONE, on a cycle with div_can_accept_cmd && div_data_ready, SHALL:
  register res_quot = div_quot, res_rem = div_rem, res_div_by_zero = 0;
  go to HOLD.
REQ-014 In HOLD, res_valid SHALL be 1 and res_quot/res_rem/res_tag/res_div_by_zero SHALL stay stable.
REQ-015 In HOLD, res_ready == 1 SHALL go to IDLE. req_ready rises one cycle later; there is no same-cycle result-to-request turnaround.
REQ-016 Latency SHALL be:
  bypass: accept edge to res_valid is 1 edge;
  divider path: divider latency + 2 edges (ISSUE to WAIT_BUSY, and WAIT_DONE capture), plus any ISSUE stall.
REQ-017 res_valid SHALL be 0 in every state other than HOLD.
REQ-018 Outstanding requests SHALL be at most one; no queueing.
REQ-019 Tag SHALL pass through unmodified on both the bypass and divider paths.

Reset
REQ-020 rst_n low SHALL immediately force:
  state = IDLE;
  res_valid = 0, div_enable = 0;
  res_quot = res_rem = 0, res_tag = 0, res_div_by_zero = 0;
  latched operands = 0.
REQ-021 Reset mid-division SHALL drop the in-flight result. The next divider-bound request SHALL stall in ISSUE until div_can_accept_cmd == 1, and WAIT_BUSY SHALL discard the stale completion.
REQ-022 req_ready SHALL be 1 in the first cycle after rst_n deasserts.

Verification
REQ-023 Unsigned 100/7, tag 3 -> one div_enable pulse; res_quot = 14, res_rem = 2, res_tag = 3, res_div_by_zero = 0.
REQ-024 Signed -7/2 (0xFFFFFFF9 / 2) -> res_quot = 0xFFFFFFFD, res_rem = 0xFFFFFFFF.
REQ-025 Denom 0, num 0x1234 -> no div_enable; res_valid the next cycle; res_quot = 0xFFFFFFFF, res_rem = 0x1234, res_div_by_zero = 1.
REQ-026 Signed 0x80000000 / 0xFFFFFFFF -> no div_enable; res_quot = 0x80000000, res_rem = 0.
REQ-027 Backpressure: res_ready held 0 for 10 cycles -> res_valid and the outputs stay stable and req_ready stays 0; one cycle after res_ready = 1, req_ready = 1.
REQ-028 Reset while in WAIT_DONE, then an immediate new request 9/4 -> no result from the aborted request; ISSUE stalls until the divider is idle; result quot = 2, rem = 1.

Source files
------------

// File: rtl/div_sequencer_if.sv
// Request/result handshake plus divider command/status bundle for div_sequencer.
// slave is the sequencer's view; master is the client plus divider side.
interface div_sequencer_if #(
    parameter int unsigned args_width = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_sgn;
    logic [args_width-1:0] req_num;
    logic [args_width-1:0] req_denom;
    logic [3:0]            req_tag;

    logic                  res_valid;
    logic                  res_ready;
    logic [args_width-1:0] res_quot;
    logic [args_width-1:0] res_rem;
    logic [3:0]            res_tag;
    logic                  res_div_by_zero;

    logic                  div_enable;
    logic                  div_unsgn_or_sgn;
    logic [args_width-1:0] div_num;
    logic [args_width-1:0] div_denom;
    logic [args_width-1:0] div_quot;
    logic [args_width-1:0] div_rem;
    logic                  div_can_accept_cmd;
    logic                  div_data_ready;

    modport slave (
        input  req_valid, req_sgn, req_num, req_denom, req_tag, res_ready,
        input  div_quot, div_rem, div_can_accept_cmd, div_data_ready,
        output req_ready, res_valid, res_quot, res_rem, res_tag, res_div_by_zero,
        output div_enable, div_unsgn_or_sgn, div_num, div_denom
    );

    modport master (
        output req_valid, req_sgn, req_num, req_denom, req_tag, res_ready,
        output div_quot, div_rem, div_can_accept_cmd, div_data_ready,
        input  req_ready, res_valid, res_quot, res_rem, res_tag, res_div_by_zero,
        input  div_enable, div_unsgn_or_sgn, div_num, div_denom
    );
endinterface

// File: rtl/div_sequencer.sv
// Single-outstanding divide sequencer: bypasses x/0 and MIN/-1 in 1 edge, else divider latency + 2 edges.
// Result is held in HOLD until res_ready; a new request is accepted only from IDLE, one cycle later.
module div_sequencer #(
    parameter int unsigned args_width = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    div_sequencer_if.slave  bus
);
    if (args_width < 8 || args_width > 128) begin : g_width_check
        $error("div_sequencer: args_width must be within 8..128");
    end

    localparam logic [args_width-1:0] MIN_NEG  = {1'b1, {(args_width-1){1'b0}}};
    localparam logic [args_width-1:0] ALL_ONES = '1;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        HOLD
    } state_t;

    state_t                state_q, state_d;
    logic                  sgn_q, sgn_d;
    logic [args_width-1:0] num_q, num_d;
    logic [args_width-1:0] denom_q, denom_d;
    logic [3:0]            tag_q, tag_d;
    logic [args_width-1:0] quot_q, quot_d;
    logic [args_width-1:0] rem_q, rem_d;
    logic                  dbz_q, dbz_d;
    logic                  div_enable;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sgn_q   <= 1'b0;
            num_q   <= '0;
            denom_q <= '0;
            tag_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sgn_q   <= sgn_d;
            num_q   <= num_d;
            denom_q <= denom_d;
            tag_q   <= tag_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sgn_d      = sgn_q;
        num_d      = num_q;
        denom_d    = denom_q;
        tag_d      = tag_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        dbz_d      = dbz_q;
        div_enable = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    sgn_d   = bus.req_sgn;
                    num_d   = bus.req_num;
                    denom_d = bus.req_denom;
                    tag_d   = bus.req_tag;
                    if (bus.req_denom == '0) begin
                        quot_d  = ALL_ONES;
                        rem_d   = bus.req_num;
                        dbz_d   = 1'b1;
                        state_d = HOLD;
                    end else if (bus.req_sgn && bus.req_num == MIN_NEG && bus.req_denom == ALL_ONES) begin
                        quot_d  = bus.req_num;
                        rem_d   = '0;
                        dbz_d   = 1'b0;
                        state_d = HOLD;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (bus.div_can_accept_cmd) begin
                    div_enable = 1'b1;
                    state_d    = WAIT_BUSY;
                end
            end
            // data_ready may still be asserted from an earlier command; wait for busy first.
            WAIT_BUSY: begin
                if (!bus.div_can_accept_cmd) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (bus.div_can_accept_cmd && bus.div_data_ready) begin
                    quot_d  = bus.div_quot;
                    rem_d   = bus.div_rem;
                    dbz_d   = 1'b0;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (bus.res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.req_ready        = (state_q == IDLE);
    assign bus.res_valid        = (state_q == HOLD);
    assign bus.res_quot         = quot_q;
    assign bus.res_rem          = rem_q;
    assign bus.res_tag          = tag_q;
    assign bus.res_div_by_zero  = dbz_q;
    assign bus.div_enable       = div_enable;
    assign bus.div_unsgn_or_sgn = sgn_q;
    assign bus.div_num          = num_q;
    assign bus.div_denom        = denom_q;
endmodule

// File: tb/tb_div_sequencer.sv
// Bench for div_sequencer: directed requests against a behavioural divider without reset,
// expected results queued at issue and checked by an independent monitor.
module tb_div_sequencer;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    div_sequencer_if #(.args_width(W)) bus();

    div_sequencer #(.args_width(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic [3:0]   tag;
        logic         dbz;
        int           en;
        int           lat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Divider model: no reset; result appears div_lat edges after the command edge,
    // and data_ready stays high until the next command.
    int           div_lat = 4;
    logic         dv_can  = 1'b1;
    logic         dv_rdy  = 1'b0;
    logic         dv_busy = 1'b0;
    int           dv_cnt  = 0;
    logic [W-1:0] dv_q    = '0;
    logic [W-1:0] dv_r    = '0;
    logic [W-1:0] dv_pq   = '0;
    logic [W-1:0] dv_pr   = '0;

    always @(posedge clk) begin
        if (dv_busy) begin
            if (dv_cnt == 1) begin
                dv_can  <= 1'b1;
                dv_rdy  <= 1'b1;
                dv_q    <= dv_pq;
                dv_r    <= dv_pr;
                dv_busy <= 1'b0;
            end
            dv_cnt <= dv_cnt - 1;
        end else if (bus.div_enable && dv_can) begin
            dv_can  <= 1'b0;
            dv_rdy  <= 1'b0;
            dv_busy <= 1'b1;
            dv_cnt  <= div_lat;
            if (bus.div_denom == '0) begin
                dv_pq <= '1;
                dv_pr <= bus.div_num;
            end else if (bus.div_unsgn_or_sgn) begin
                dv_pq <= $signed(bus.div_num) / $signed(bus.div_denom);
                dv_pr <= $signed(bus.div_num) % $signed(bus.div_denom);
            end else begin
                dv_pq <= bus.div_num / bus.div_denom;
                dv_pr <= bus.div_num % bus.div_denom;
            end
        end
    end

    assign bus.div_can_accept_cmd = dv_can;
    assign bus.div_data_ready     = dv_rdy;
    assign bus.div_quot           = dv_q;
    assign bus.div_rem            = dv_r;

    // Monitor: latency is counted in edges, the accept edge included.
    int acc_cyc  = 0;
    int en_cnt   = 0;
    int lat      = 0;
    bit vld_prev = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            vld_prev = 1'b0;
        end else begin
            if (bus.req_valid && bus.req_ready) begin
                acc_cyc = cyc;
                en_cnt  = 0;
            end
            if (bus.div_enable) en_cnt++;
            if (bus.res_valid && !vld_prev) lat = cyc - acc_cyc;
            vld_prev = bus.res_valid;
            if (bus.res_valid && bus.res_ready) begin
                chk("result_expected", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    chk("res_quot",         64'(bus.res_quot), 64'(mon_e.q));
                    chk("res_rem",          64'(bus.res_rem), 64'(mon_e.r));
                    chk("res_tag",          64'(bus.res_tag), 64'(mon_e.tag));
                    chk("res_div_by_zero",  64'(bus.res_div_by_zero), 64'(mon_e.dbz));
                    chk("div_enable_count", 64'(en_cnt), 64'(mon_e.en));
                    chk("latency",          64'(lat), 64'(mon_e.lat));
                end
            end
        end
    end

    task automatic send(input logic sgn, input logic [W-1:0] n, input logic [W-1:0] d,
                        input logic [3:0] tag, input logic [W-1:0] eq, input logic [W-1:0] er,
                        input logic edbz, input int een, input int elat, input bit push);
        exp_t e;
        int   t;
        if (push) begin
            e.q = eq; e.r = er; e.tag = tag; e.dbz = edbz; e.en = een; e.lat = elat;
            sb.push_back(e);
        end
        bus.req_sgn   = sgn;
        bus.req_num   = n;
        bus.req_denom = d;
        bus.req_tag   = tag;
        bus.req_valid = 1'b1;
        t = 0;
        while (!bus.req_ready && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        chk("req_ready_for_accept", 64'(bus.req_ready), 64'd1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (!(sb.size() == 0 && bus.req_ready) && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        chk("drain_in_time", 64'(t < 300), 64'd1);
    endtask

    task automatic chk_reset_state(input string tagname);
        chk({tagname, "_res_valid"},  64'(bus.res_valid), 64'd0);
        chk({tagname, "_div_enable"}, 64'(bus.div_enable), 64'd0);
        chk({tagname, "_req_ready"},  64'(bus.req_ready), 64'd1);
        chk({tagname, "_res_quot"},   64'(bus.res_quot), 64'd0);
        chk({tagname, "_res_rem"},    64'(bus.res_rem), 64'd0);
        chk({tagname, "_res_tag"},    64'(bus.res_tag), 64'd0);
        chk({tagname, "_res_dbz"},    64'(bus.res_div_by_zero), 64'd0);
        chk({tagname, "_div_num"},    64'(bus.div_num), 64'd0);
        chk({tagname, "_div_denom"},  64'(bus.div_denom), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_sgn   = 1'b0;
        bus.req_num   = '0;
        bus.req_denom = '0;
        bus.req_tag   = '0;
        bus.res_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_state("reset");
        rst_n = 1'b1;
        chk("req_ready_after_reset", 64'(bus.req_ready), 64'd1);

        // unsigned, signed, zero-denominator bypass, signed-overflow bypass, unsigned MIN/all-ones
        send(1'b0, 32'd100,        32'd7,        4'h3, 32'd14,       32'd2,        1'b0, 1, 7, 1'b1);
        wait_idle();
        send(1'b1, 32'hFFFF_FFF9,  32'd2,        4'h5, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1, 7, 1'b1);
        wait_idle();
        send(1'b0, 32'h0000_1234,  32'd0,        4'h9, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1, 0, 1, 1'b1);
        wait_idle();
        send(1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 4'hA, 32'h8000_0000, 32'd0,       1'b0, 0, 1, 1'b1);
        wait_idle();
        send(1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 4'h6, 32'd0,        32'h8000_0000, 1'b0, 1, 7, 1'b1);
        wait_idle();

        // Backpressure: result must hold for 10 cycles while res_ready is low.
        bus.res_ready = 1'b0;
        send(1'b0, 32'd1000, 32'd10, 4'hC, 32'd100, 32'd0, 1'b0, 1, 7, 1'b1);
        t = 0;
        while (!bus.res_valid && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        chk("bp_res_valid_seen", 64'(bus.res_valid), 64'd1);
        for (int i = 0; i < 10; i++) begin
            chk("bp_res_valid", 64'(bus.res_valid), 64'd1);
            chk("bp_req_ready", 64'(bus.req_ready), 64'd0);
            chk("bp_res_quot",  64'(bus.res_quot), 64'd100);
            chk("bp_res_rem",   64'(bus.res_rem), 64'd0);
            chk("bp_res_tag",   64'(bus.res_tag), 64'hC);
            chk("bp_res_dbz",   64'(bus.res_div_by_zero), 64'd0);
            chk("bp_div_num",   64'(bus.div_num), 64'd1000);
            @(posedge clk); #1;
        end
        bus.res_ready = 1'b1;
        chk("bp_req_ready_same_cycle", 64'(bus.req_ready), 64'd0);
        @(posedge clk); #1;
        chk("bp_req_ready_next_cycle", 64'(bus.req_ready), 64'd1);
        chk("bp_res_valid_dropped",    64'(bus.res_valid), 64'd0);
        wait_idle();

        // Reset in WAIT_DONE with a slow divider; the follow-up request stalls in ISSUE.
        div_lat = 8;
        send(1'b0, 32'd50, 32'd3, 4'hE, 32'd0, 32'd0, 1'b0, 0, 0, 1'b0);
        t = 0;
        while (!bus.div_enable && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        chk("abort_div_enable_seen", 64'(bus.div_enable), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_state("mid_reset");
        @(posedge clk); #1;
        rst_n   = 1'b1;
        div_lat = 4;
        chk("req_ready_after_mid_reset", 64'(bus.req_ready), 64'd1);
        send(1'b0, 32'd9, 32'd4, 4'h7, 32'd2, 32'd1, 1'b0, 1, 11, 1'b1);
        wait_idle();

        repeat (5) @(posedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
